// File: rtl/data_memory_bytelane.sv
// Byte-lane data memory for the RV32 MEM stage: sub-word loads/stores, range/alignment/illegal fault reporting.
// Latency: load data and fault pulses one edge after the request; no backpressure, a request is accepted every cycle.
module data_memory_bytelane #(
    parameter int unsigned                DEPTH_WORDS = 1024,
    parameter int unsigned                ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR   = '0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [31:0]           WRITE_DATA,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            FUNCT3,
    output logic [31:0]           READ_DATA,
    output logic                  READ_VALID,
    output logic                  FAULT,
    output logic [1:0]            FAULT_CAUSE
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE = 2'b10;
    localparam logic [1:0] CAUSE_ILL   = 2'b11;

    logic [31:0]           r_mem [DEPTH_WORDS];
    logic [31:0]           r_read_data;
    logic                  r_read_valid;
    logic                  r_fault;
    logic [1:0]            r_fault_cause;

    logic [ADDR_WIDTH-1:0] w_rel;
    logic [IDX_W-1:0]      w_idx;
    logic [1:0]            w_off;
    logic                  w_load;
    logic                  w_store;
    logic                  w_req;
    logic                  w_f3_ok;
    logic                  w_illegal;
    logic                  w_oor;
    logic                  w_misal;
    logic [1:0]            w_cause;
    logic                  w_fault;
    logic [3:0]            w_be;
    logic [31:0]           w_wlanes;
    logic [31:0]           w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_data;

    always_comb begin
        w_rel   = ADDRESS - BASE_ADDR;
        w_idx   = w_rel[IDX_W+1:2];
        w_off   = ADDRESS[1:0];
        w_load  = MemRead & ~MemWrite;
        w_store = MemWrite & ~MemRead;
        w_req   = MemRead | MemWrite;

        w_f3_ok = 1'b0;
        case (FUNCT3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = w_load;
            default:                w_f3_ok = 1'b0;
        endcase

        w_illegal = (MemRead & MemWrite) | (w_req & ~w_f3_ok);
        // Below-base addresses wrap in w_rel, so they are caught explicitly.
        w_oor     = (ADDRESS < BASE_ADDR) || ((w_rel >> (IDX_W + 2)) != '0);
        w_misal   = ((FUNCT3[1:0] == 2'b01) && w_off[0]) ||
                    ((FUNCT3[1:0] == 2'b10) && (w_off != 2'b00));

        if (w_illegal)      w_cause = CAUSE_ILL;
        else if (w_oor)     w_cause = CAUSE_RANGE;
        else if (w_misal)   w_cause = CAUSE_ALIGN;
        else                w_cause = CAUSE_NONE;
        w_fault = w_req & (w_cause != CAUSE_NONE);

        w_be     = 4'b0000;
        w_wlanes = WRITE_DATA;
        case (FUNCT3[1:0])
            2'b00: begin
                w_be     = 4'b0001 << w_off;
                w_wlanes = {4{WRITE_DATA[7:0]}};
            end
            2'b01: begin
                w_be     = 4'b0011 << w_off;
                w_wlanes = {2{WRITE_DATA[15:0]}};
            end
            default: begin
                w_be     = 4'b1111;
                w_wlanes = WRITE_DATA;
            end
        endcase

        w_word = r_mem[w_idx];
        w_byte = w_word[{w_off, 3'b000} +: 8];
        w_half = w_word[{w_off[1], 4'b0000} +: 16];
        case (FUNCT3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'h000000, w_byte};
            3'b101:  w_load_data = {16'h0000, w_half};
            default: w_load_data = w_word;
        endcase
    end

    // Array has no reset: contents survive RESET, only the write is suppressed.
    always_ff @(posedge CLK) begin
        if (!RESET && w_store && !w_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_read_data   <= 32'h0;
            r_read_valid  <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_cause <= CAUSE_NONE;
        end else begin
            r_read_valid <= w_load & ~w_fault;
            r_fault      <= w_fault;
            if (w_fault)           r_fault_cause <= w_cause;
            if (w_load && !w_fault) r_read_data  <= w_load_data;
        end
    end

    assign READ_DATA   = r_read_data;
    assign READ_VALID  = r_read_valid;
    assign FAULT       = r_fault;
    assign FAULT_CAUSE = r_fault_cause;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed vector bench for data_memory_bytelane: table of single-cycle requests plus reset sequences.
module tb_data_memory_bytelane;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [AW-1:0] ADDRESS;
    logic [31:0]   WRITE_DATA;
    logic          MemRead;
    logic          MemWrite;
    logic [2:0]    FUNCT3;
    logic [31:0]   READ_DATA;
    logic          READ_VALID;
    logic          FAULT;
    logic [1:0]    FAULT_CAUSE;

    data_memory_bytelane #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
        .CLK(CLK), .RESET(RESET), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
        .MemRead(MemRead), .MemWrite(MemWrite), .FUNCT3(FUNCT3),
        .READ_DATA(READ_DATA), .READ_VALID(READ_VALID), .FAULT(FAULT), .FAULT_CAUSE(FAULT_CAUSE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] e_data;
        logic        e_vld;
        logic        e_flt;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input string name, input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] e_data,
                       input logic e_vld, input logic e_flt, input logic [1:0] e_cause);
        vec_t v;
        v.name = name; v.mr = mr; v.mw = mw; v.f3 = f3; v.addr = addr; v.wd = wd;
        v.e_data = e_data; v.e_vld = e_vld; v.e_flt = e_flt; v.e_cause = e_cause;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        RESET = rst; MemRead = mr; MemWrite = mw; FUNCT3 = f3; ADDRESS = addr; WRITE_DATA = wd;
    endtask

    task automatic check(input string name, input logic [31:0] e_data, input logic e_vld,
                         input logic e_flt, input logic [1:0] e_cause);
        n_cmp++;
        if (READ_DATA !== e_data || READ_VALID !== e_vld || FAULT !== e_flt || FAULT_CAUSE !== e_cause) begin
            n_bad++;
            $display("FAIL %s: got data=%08h vld=%b flt=%b cause=%b, want data=%08h vld=%b flt=%b cause=%b",
                     name, READ_DATA, READ_VALID, FAULT, FAULT_CAUSE, e_data, e_vld, e_flt, e_cause);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        step();
        step();
        check("reset_state", 32'h0, 1'b0, 1'b0, 2'b00);

        //   name          mr mw f3      addr          wdata         e_data        vld  flt  cause
        add("sw_10",       0, 1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        0,   0,   2'b00);
        add("lw_10",       1, 0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1,   0,   2'b00);
        add("idle_hold",   0, 0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 0,   0,   2'b00);
        add("lb_13",       1, 0, 3'b000, 32'h13,       32'h0,        32'hFFFFFFDE, 1,   0,   2'b00);
        add("lbu_13",      1, 0, 3'b100, 32'h13,       32'h0,        32'h000000DE, 1,   0,   2'b00);
        add("lh_10",       1, 0, 3'b001, 32'h10,       32'h0,        32'hFFFFBEEF, 1,   0,   2'b00);
        add("lhu_12",      1, 0, 3'b101, 32'h12,       32'h0,        32'h0000DEAD, 1,   0,   2'b00);
        add("sw_20_zero",  0, 1, 3'b010, 32'h20,       32'h0,        32'h0000DEAD, 0,   0,   2'b00);
        add("sb_21",       0, 1, 3'b000, 32'h21,       32'hFFFFFFAB, 32'h0000DEAD, 0,   0,   2'b00);
        add("sh_22",       0, 1, 3'b001, 32'h22,       32'hCDEF1234, 32'h0000DEAD, 0,   0,   2'b00);
        add("lw_20_merge", 1, 0, 3'b010, 32'h20,       32'h0,        32'h1234AB00, 1,   0,   2'b00);
        add("lb_22_pos",   1, 0, 3'b000, 32'h22,       32'h0,        32'h00000034, 1,   0,   2'b00);
        add("lw_11_misal", 1, 0, 3'b010, 32'h11,       32'h0,        32'h00000034, 0,   1,   2'b01);
        add("lw_10_a",     1, 0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1,   0,   2'b01);
        add("sh_13_misal", 0, 1, 3'b001, 32'h13,       32'h00009999, 32'hDEADBEEF, 0,   1,   2'b01);
        add("lw_10_b",     1, 0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1,   0,   2'b01);
        add("lw_oor",      1, 0, 3'b010, 32'h1000,     32'h0,        32'hDEADBEEF, 0,   1,   2'b10);
        add("sw_oor",      0, 1, 3'b010, 32'h1000,     32'h0,        32'hDEADBEEF, 0,   1,   2'b10);
        add("lw_0_alias",  1, 0, 3'b010, 32'h0,        32'h0,        32'hXXXXXXXX, 1,   0,   2'b10);
        add("lw_10_c",     1, 0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1,   0,   2'b10);
        add("f3_011",      1, 0, 3'b011, 32'h10,       32'h0,        32'hDEADBEEF, 0,   1,   2'b11);
        add("lw_10_d",     1, 0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1,   0,   2'b11);
        add("rd_and_wr",   1, 1, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 0,   1,   2'b11);
        add("lw_10_e",     1, 0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1,   0,   2'b11);
        add("prio_ill",    1, 0, 3'b111, 32'h1001,     32'h0,        32'hDEADBEEF, 0,   1,   2'b11);
        add("prio_oor",    1, 0, 3'b010, 32'h1001,     32'h0,        32'hDEADBEEF, 0,   1,   2'b10);
        add("idle_cause",  0, 0, 3'b010, 32'h0,        32'h0,        32'hDEADBEEF, 0,   0,   2'b10);
        add("sbu_store",   0, 1, 3'b100, 32'h10,       32'h00000011, 32'hDEADBEEF, 0,   1,   2'b11);
        add("lb_10",       1, 0, 3'b000, 32'h10,       32'h0,        32'hFFFFFFEF, 1,   0,   2'b11);
        add("lbu_11",      1, 0, 3'b100, 32'h11,       32'h0,        32'h000000BE, 1,   0,   2'b11);
        add("lh_12",       1, 0, 3'b001, 32'h12,       32'h0,        32'hFFFFDEAD, 1,   0,   2'b11);

        // Word 0 was never written; store a known value first so the alias check is deterministic.
        drive(1'b0, 1'b0, 1'b1, 3'b010, 32'h0, 32'hA5A5_0F0F);
        step();
        check("sw_0_init", 32'h0, 1'b0, 1'b0, 2'b00);
        foreach (vecs[i]) begin
            if (vecs[i].name == "lw_0_alias") vecs[i].e_data = 32'hA5A5_0F0F;
        end

        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].mr, vecs[i].mw, vecs[i].f3, vecs[i].addr, vecs[i].wd);
            step();
            check(vecs[i].name, vecs[i].e_data, vecs[i].e_vld, vecs[i].e_flt, vecs[i].e_cause);
        end

        // Store on a reset edge is discarded and the array keeps its prior contents.
        drive(1'b0, 1'b0, 1'b1, 3'b010, 32'h30, 32'h11223344);
        step();
        check("sw_30_pre", 32'hFFFFDEAD, 1'b0, 1'b0, 2'b11);
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h30, 32'h00000055);
        step();
        check("rst_with_sw", 32'h0, 1'b0, 1'b0, 2'b00);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        step();
        check("lw_30_after_rst", 32'h11223344, 1'b1, 1'b0, 2'b00);

        // Load on a reset edge produces no valid pulse, then or later.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        step();
        check("rst_with_lw", 32'h0, 1'b0, 1'b0, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        step();
        check("post_rst_idle", 32'h0, 1'b0, 1'b0, 2'b00);

        // Fault pulse lasts one cycle while the cause is held.
        drive(1'b0, 1'b1, 1'b0, 3'b001, 32'h11, 32'h0);
        step();
        check("lh_11_misal", 32'h0, 1'b0, 1'b1, 2'b01);
        drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        step();
        check("fault_drop", 32'h0, 1'b0, 1'b0, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
